// File: rtl/axi4_lite_subordinate_pkg.sv
// Shared AXI4-Lite response codes and helpers for subordinate-side blocks.
// Pure definitions: no latency and no flow control.
package axi4_lite_subordinate_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    function automatic resp_t resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi4_lite_subordinate.sv
// AXI4-Lite to strobe-register bridge, one transaction in flight; strobe in N+1, response in N+2 with reg_ready=1.
// Backpressure: channel readys drop outside IDLE/WR_COLLECT; responses hold until bready/rready; watchdog forces SLVERR.
module axi4_lite_subordinate
    import axi4_lite_subordinate_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [WIDTH-1:0]      rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  reg_rd_en,
    output logic                  reg_wr_en,
    output logic [ADDR_WIDTH-3:0] reg_addr,
    output logic [WIDTH-1:0]      reg_wr_data,
    output logic [WIDTH/8-1:0]    reg_wr_strobe,
    input  logic [WIDTH-1:0]      reg_rd_data,
    input  logic                  reg_ready,
    input  logic                  reg_error
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WR_COLLECT = 3'd1;
    localparam logic [2:0] S_WR_ACCESS  = 3'd2;
    localparam logic [2:0] S_WR_RESP    = 3'd3;
    localparam logic [2:0] S_RD_ACCESS  = 3'd4;
    localparam logic [2:0] S_RD_RESP    = 3'd5;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          prio_wr;
    logic          have_aw;
    logic          have_w;
    logic          wr_any;
    logic          wr_sel;
    logic          rd_sel;
    logic          aw_hs;
    logic          w_hs;
    logic          ar_hs;
    logic          unused_addr_lsbs;

    // Byte-offset bits carry no meaning for word registers.
    assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

    // On a write/read collision only the prioritised side sees ready.
    assign wr_any = awvalid | wvalid;
    assign wr_sel = !arvalid || prio_wr;
    assign rd_sel = !wr_any || !prio_wr;

    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        arready = 1'b0;
        if (!rst) begin
            if (state == S_IDLE) begin
                awready = wr_sel;
                wready  = wr_sel;
                arready = rd_sel;
            end else if (state == S_WR_COLLECT) begin
                awready = !have_aw;
                wready  = !have_w;
            end
        end
    end

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign ar_hs = arvalid & arready;

    assign reg_wr_en = (state == S_WR_ACCESS);
    assign reg_rd_en = (state == S_RD_ACCESS);
    assign bvalid    = (state == S_WR_RESP);
    assign rvalid    = (state == S_RD_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            prio_wr       <= 1'b1;
            have_aw       <= 1'b0;
            have_w        <= 1'b0;
            reg_addr      <= '0;
            reg_wr_data   <= '0;
            reg_wr_strobe <= '0;
            rdata         <= '0;
            rresp         <= RESP_OKAY;
            bresp         <= RESP_OKAY;
        end else begin
            case (state)
                S_IDLE, S_WR_COLLECT: begin
                    if (aw_hs) reg_addr <= awaddr[ADDR_WIDTH-1:2];
                    if (w_hs) begin
                        reg_wr_data   <= wdata;
                        reg_wr_strobe <= wstrb;
                    end
                    if ((aw_hs && w_hs) || (state == S_WR_COLLECT && (aw_hs || w_hs))) begin
                        state   <= S_WR_ACCESS;
                        cnt     <= '0;
                        have_aw <= 1'b0;
                        have_w  <= 1'b0;
                    end else if (aw_hs || w_hs) begin
                        state   <= S_WR_COLLECT;
                        have_aw <= aw_hs;
                        have_w  <= w_hs;
                    end else if (ar_hs) begin
                        reg_addr <= araddr[ADDR_WIDTH-1:2];
                        state    <= S_RD_ACCESS;
                        cnt      <= '0;
                    end
                end
                S_WR_ACCESS, S_RD_ACCESS: begin
                    if (cnt < CNT_MAX) cnt <= cnt + 1'b1;
                    if (reg_ready) begin
                        if (state == S_RD_ACCESS) begin
                            rdata <= reg_rd_data;
                            rresp <= resp_of(reg_error);
                            state <= S_RD_RESP;
                        end else begin
                            bresp <= resp_of(reg_error);
                            state <= S_WR_RESP;
                        end
                    end else if (cnt >= CNT_LAST) begin
                        // Watchdog expired: the peripheral never answered.
                        if (state == S_RD_ACCESS) begin
                            rdata <= '0;
                            rresp <= RESP_SLVERR;
                            state <= S_RD_RESP;
                        end else begin
                            bresp <= RESP_SLVERR;
                            state <= S_WR_RESP;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (bready) begin
                        state   <= S_IDLE;
                        prio_wr <= !prio_wr;
                    end
                end
                S_RD_RESP: begin
                    if (rready) begin
                        state   <= S_IDLE;
                        prio_wr <= !prio_wr;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_subordinate.sv
// Directed bench for axi4_lite_subordinate: vector table of single transactions plus collision, hold and reset sequences.
module tb_axi4_lite_subordinate;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        reg_rd_en;
    logic        reg_wr_en;
    logic [5:0]  reg_addr;
    logic [31:0] reg_wr_data;
    logic [3:0]  reg_wr_strobe;
    logic [31:0] reg_rd_data = '0;
    logic        reg_ready = 1'b0;
    logic        reg_error = 1'b0;

    axi4_lite_subordinate #(.WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
        .reg_wr_data(reg_wr_data), .reg_wr_strobe(reg_wr_strobe),
        .reg_rd_data(reg_rd_data), .reg_ready(reg_ready), .reg_error(reg_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdd;
        int          delay;
        bit          err;
        logic [5:0]  exp_addr;
        int          exp_pulses;
        int          exp_lat;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    int errors = 0;
    int checks = 0;

    int          m_pulses;
    int          m_lat;
    logic [5:0]  m_addr;
    logic [31:0] m_wd;
    logic [3:0]  m_strb;
    logic [1:0]  m_resp;
    logic [31:0] m_rdata;
    bit          m_wrong;
    bit          m_strobe_at_resp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int out_ones();
        return $countones({awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
                           reg_rd_en, reg_wr_en, reg_addr, reg_wr_data, reg_wr_strobe});
    endfunction

    task automatic wait_hs(input bit wr);
        int n = 0;
        while (n < 20 && !(wr ? (awready && wready) : arready)) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) chk("handshake_timeout", 32'(n), 32'd0);
    endtask

    // Peripheral model: answers on the (delay+1)-th strobe cycle; delay>=16 never answers.
    task automatic monitor(input bit is_wr, input int delay, input bit err, input logic [31:0] rdd);
        bit done = 1'b0;
        m_pulses = 0; m_lat = 0; m_wrong = 1'b0; m_strobe_at_resp = 1'b0;
        m_addr = '0; m_wd = '0; m_strb = '0; m_resp = '0; m_rdata = '0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            m_wrong |= is_wr ? reg_rd_en : reg_wr_en;
            if (bvalid || rvalid) begin
                m_lat = k;
                m_resp = is_wr ? bresp : rresp;
                m_rdata = rdata;
                m_strobe_at_resp = reg_wr_en | reg_rd_en;
                done = 1'b1;
            end
            if (reg_wr_en || reg_rd_en) begin
                if (m_pulses == 0) begin
                    m_addr = reg_addr; m_wd = reg_wr_data; m_strb = reg_wr_strobe;
                end
                reg_ready = (m_pulses == delay);
                reg_error = err;
                reg_rd_data = rdd;
                m_pulses++;
            end else begin
                reg_ready = 1'b0;
                reg_error = 1'b0;
            end
        end
        reg_ready = 1'b0;
        reg_error = 1'b0;
    endtask

    task automatic respond(input bit is_wr, input string tag);
        if (is_wr) bready = 1'b1; else rready = 1'b1;
        @(posedge clk);
        #1;
        bready = 1'b0;
        rready = 1'b0;
        @(negedge clk);
        chk({tag, "_valid_drop"}, 32'(bvalid | rvalid), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        if (v.is_wr) begin
            awaddr = v.addr; wdata = v.wdata; wstrb = v.wstrb; awvalid = 1'b1; wvalid = 1'b1;
        end else begin
            araddr = v.addr; arvalid = 1'b1;
        end
        #1;
        wait_hs(v.is_wr);
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        monitor(v.is_wr, v.delay, v.err, v.rdd);
        chk({t, "_addr"}, 32'(m_addr), 32'(v.exp_addr));
        chk({t, "_pulses"}, 32'(m_pulses), 32'(v.exp_pulses));
        chk({t, "_latency"}, 32'(m_lat), 32'(v.exp_lat));
        chk({t, "_resp"}, 32'(m_resp), 32'(v.exp_resp));
        chk({t, "_strobe_low_at_resp"}, 32'(m_strobe_at_resp), 32'd0);
        chk({t, "_wrong_strobe"}, 32'(m_wrong), 32'd0);
        if (v.is_wr) begin
            chk({t, "_wdata"}, m_wd, v.wdata);
            chk({t, "_wstrb"}, 32'(m_strb), 32'(v.wstrb));
        end else begin
            chk({t, "_rdata"}, m_rdata, v.exp_rdata);
        end
        respond(v.is_wr, t);
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int bad;
        logic [31:0] held;

        //          wr    addr   wdata         wstrb rdd           dly err exp_addr pls lat resp   rdata
        vecs[0] = '{1'b0, 8'h14, 32'h0,        4'h0, 32'hDEADBEEF, 0,  1'b0, 6'h05, 1,  2,  2'b00, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 8'h08, 32'h12345678, 4'h3, 32'h0,        0,  1'b0, 6'h02, 1,  2,  2'b00, 32'h0};
        vecs[2] = '{1'b0, 8'h3F, 32'h0,        4'h0, 32'hA5A50001, 3,  1'b0, 6'h0F, 4,  5,  2'b00, 32'hA5A50001};
        vecs[3] = '{1'b1, 8'hFC, 32'hCAFEF00D, 4'hF, 32'h0,        2,  1'b1, 6'h3F, 3,  4,  2'b10, 32'h0};
        vecs[4] = '{1'b0, 8'h20, 32'h0,        4'h0, 32'h11112222, 1,  1'b1, 6'h08, 2,  3,  2'b10, 32'h11112222};
        vecs[5] = '{1'b0, 8'h04, 32'h0,        4'h0, 32'h77777777, 99, 1'b0, 6'h01, 16, 17, 2'b10, 32'h0};
        vecs[6] = '{1'b1, 8'h10, 32'hFFFFFFFF, 4'h0, 32'h0,        0,  1'b0, 6'h04, 1,  2,  2'b00, 32'h0};
        vecs[7] = '{1'b1, 8'h33, 32'h5A5A5A5A, 4'hC, 32'h0,        99, 1'b0, 6'h0C, 16, 17, 2'b10, 32'h0};

        // Reset state
        @(negedge clk);
        chk("rst_outputs_zero", 32'(out_ones()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_readys", 32'({awready, wready, arready}), 32'b111);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // W three cycles ahead of AW
        @(negedge clk);
        wdata = 32'h12345678; wstrb = 4'b0011; wvalid = 1'b1;
        #1;
        chk("wfirst_wready", 32'(wready), 32'd1);
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        @(negedge clk);
        #1;
        chk("wfirst_collect_readys", 32'({awready, wready, arready}), 32'b100);
        @(negedge clk);
        @(negedge clk);
        awaddr = 8'h08; awvalid = 1'b1;
        #1;
        chk("wfirst_awready", 32'(awready), 32'd1);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        monitor(1'b1, 0, 1'b0, 32'h0);
        chk("wfirst_pulses", 32'(m_pulses), 32'd1);
        chk("wfirst_addr", 32'(m_addr), 32'd2);
        chk("wfirst_wdata", m_wd, 32'h12345678);
        chk("wfirst_wstrb", 32'(m_strb), 32'h3);
        chk("wfirst_resp", 32'(m_resp), 32'd0);
        respond(1'b1, "wfirst");

        // Write/read collisions, alternating priority
        do_rst();
        @(negedge clk);
        awaddr = 8'h40; wdata = 32'hAA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h44; arvalid = 1'b1;
        #1;
        chk("prio1_readys", 32'({awready, wready, arready}), 32'b110);
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        monitor(1'b1, 0, 1'b0, 32'h0);
        chk("prio1_addr", 32'(m_addr), 32'h10);
        chk("prio1_wrong", 32'(m_wrong), 32'd0);
        respond(1'b1, "prio1");
        awaddr = 8'h48; wdata = 32'hBB; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        chk("prio2_readys", 32'({awready, wready, arready}), 32'b001);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        monitor(1'b0, 0, 1'b0, 32'h44444444);
        chk("prio2_addr", 32'(m_addr), 32'h11);
        chk("prio2_rdata", m_rdata, 32'h44444444);
        chk("prio2_wrong", 32'(m_wrong), 32'd0);
        respond(1'b0, "prio2");
        araddr = 8'h4C; arvalid = 1'b1;
        #1;
        chk("prio3_readys", 32'({awready, wready, arready}), 32'b110);
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        monitor(1'b1, 0, 1'b0, 32'h0);
        chk("prio3_addr", 32'(m_addr), 32'h12);
        chk("prio3_wdata", m_wd, 32'hBB);
        respond(1'b1, "prio3");
        #1;
        chk("prio4_readys", 32'({awready, wready, arready}), 32'b001);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        monitor(1'b0, 0, 1'b0, 32'h55555555);
        chk("prio4_addr", 32'(m_addr), 32'h13);
        respond(1'b0, "prio4");

        // rready withheld for 10 cycles
        @(negedge clk);
        araddr = 8'h18; arvalid = 1'b1;
        #1;
        wait_hs(1'b0);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        monitor(1'b0, 0, 1'b0, 32'h0BADF00D);
        chk("hold_rdata", m_rdata, 32'h0BADF00D);
        held = rdata;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rvalid || rdata !== held || rresp !== 2'b00 || arready) bad++;
        end
        chk("hold_stable_cycles_bad", 32'(bad), 32'd0);
        respond(1'b0, "hold");

        // Reset in the middle of a write access
        @(negedge clk);
        awaddr = 8'h24; wdata = 32'h01020304; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        wait_hs(1'b1);
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("abort_strobe_on", 32'(reg_wr_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs_zero", 32'(out_ones()), 32'd0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bvalid || reg_wr_en) bad++;
        end
        chk("abort_no_bvalid", 32'(bad), 32'd0);
        #1;
        chk("abort_idle_readys", 32'({awready, wready, arready}), 32'b111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1);
    end

endmodule
